// File: rtl/dmem_arbiter.sv
// Two-port round-robin arbiter onto one byte-addressed data RAM; size strobes, load align/extend, misalign flag.
// Latency: req sampled at edge T -> gnt during T+1 -> rvalid during T+2; one access per two cycles.
// Backpressure: requesters hold req and fields until gnt; a losing port simply waits, nothing is queued.
module dmem_arbiter #(
    parameter int ADDRESS_LENGTH = 32,
    parameter int NUM_PORTS      = 2
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_PORTS-1:0]      req,
    input  logic [NUM_PORTS-1:0]      we,
    input  logic [1:0]                size0,
    input  logic [1:0]                size1,
    input  logic [NUM_PORTS-1:0]      uns,
    input  logic [ADDRESS_LENGTH-1:0] addr0,
    input  logic [ADDRESS_LENGTH-1:0] addr1,
    input  logic [ADDRESS_LENGTH-1:0] wdata0,
    input  logic [ADDRESS_LENGTH-1:0] wdata1,
    output logic [NUM_PORTS-1:0]      gnt,
    output logic [NUM_PORTS-1:0]      rvalid,
    output logic [ADDRESS_LENGTH-1:0] rdata,
    output logic                      err,
    output logic                      ram_sb,
    output logic                      ram_sh,
    output logic                      ram_sw,
    output logic [ADDRESS_LENGTH-1:0] ram_wa,
    output logic [ADDRESS_LENGTH-1:0] ram_ra,
    output logic [ADDRESS_LENGTH-1:0] ram_wd,
    input  logic [ADDRESS_LENGTH-1:0] ram_rd
);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t                    state, state_nxt;
    logic                      latch_en;
    logic                      arb_vld;
    logic                      arb_win;
    logic                      last_served;
    logic                      lat_id;
    logic                      lat_we;
    logic                      lat_uns;
    logic [1:0]                lat_size;
    logic [ADDRESS_LENGTH-1:0] lat_addr;
    logic [ADDRESS_LENGTH-1:0] lat_wdata;
    logic [ADDRESS_LENGTH-1:0] rdata_q;
    logic                      err_q;
    logic                      acc_err;
    logic                      wr_ok;
    logic [7:0]                lane_b;
    logic [15:0]               lane_h;
    logic [ADDRESS_LENGTH-1:0] load_val;

    // On a conflict the port that was not served last wins.
    assign arb_vld = |req;
    assign arb_win = (req[0] & req[1]) ? ~last_served : req[1];

    always_comb begin
        state_nxt = state;
        latch_en  = 1'b0;
        case (state)
            IDLE: begin
                if (arb_vld) begin
                    state_nxt = ACCESS;
                    latch_en  = 1'b1;
                end
            end
            ACCESS: state_nxt = RESP;
            RESP: begin
                if (arb_vld) begin
                    state_nxt = ACCESS;
                    latch_en  = 1'b1;
                end else begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            last_served <= 1'b1;
            lat_id      <= 1'b0;
            lat_we      <= 1'b0;
            lat_uns     <= 1'b0;
            lat_size    <= 2'b00;
            lat_addr    <= '0;
            lat_wdata   <= '0;
            rdata_q     <= '0;
            err_q       <= 1'b0;
        end else begin
            state <= state_nxt;
            if (latch_en) begin
                lat_id    <= arb_win;
                lat_we    <= we[arb_win];
                lat_uns   <= uns[arb_win];
                lat_size  <= arb_win ? size1 : size0;
                lat_addr  <= arb_win ? addr1 : addr0;
                lat_wdata <= arb_win ? wdata1 : wdata0;
            end
            if (state == ACCESS) begin
                last_served <= lat_id;
                err_q       <= acc_err;
                rdata_q     <= (lat_we || acc_err) ? '0 : load_val;
            end
        end
    end

    always_comb begin
        case (lat_size)
            2'b00:   acc_err = 1'b0;
            2'b01:   acc_err = lat_addr[0];
            2'b10:   acc_err = |lat_addr[1:0];
            default: acc_err = 1'b1;
        endcase
    end

    // RAM returns the whole aligned word; pick the addressed lane and extend it.
    always_comb begin
        case (lat_addr[1:0])
            2'd0:    lane_b = ram_rd[7:0];
            2'd1:    lane_b = ram_rd[15:8];
            2'd2:    lane_b = ram_rd[23:16];
            default: lane_b = ram_rd[31:24];
        endcase
        lane_h = lat_addr[1] ? ram_rd[31:16] : ram_rd[15:0];
        case (lat_size)
            2'b00:   load_val = {{(ADDRESS_LENGTH-8){~lat_uns & lane_b[7]}}, lane_b};
            2'b01:   load_val = {{(ADDRESS_LENGTH-16){~lat_uns & lane_h[15]}}, lane_h};
            default: load_val = ram_rd;
        endcase
    end

    // Pulses are gated by rst_n so an access caught by reset never reaches the RAM or the requester.
    always_comb begin
        gnt            = '0;
        rvalid         = '0;
        gnt[lat_id]    = rst_n && (state == ACCESS);
        rvalid[lat_id] = rst_n && (state == RESP);
    end

    assign wr_ok  = rst_n && (state == ACCESS) && lat_we && !acc_err;
    assign ram_sb = wr_ok && (lat_size == 2'b00);
    assign ram_sh = wr_ok && (lat_size == 2'b01);
    assign ram_sw = wr_ok && (lat_size == 2'b10);
    assign ram_wa = lat_addr;
    assign ram_ra = lat_addr;
    assign ram_wd = lat_wdata;
    assign rdata  = (rst_n && state == RESP) ? rdata_q : '0;
    assign err    = rst_n && (state == RESP) && err_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboarded random/directed bench for dmem_arbiter against a byte-level memory model.
module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req0_v, req1_v, we0_v, we1_v, uns0_v, uns1_v;
    logic [1:0]  size0, size1;
    logic [31:0] addr0, addr1, wdata0, wdata1;
    logic [1:0]  gnt, rvalid;
    logic [31:0] rdata, ram_wa, ram_ra, ram_wd, ram_rd;
    logic        err, ram_sb, ram_sh, ram_sw;

    always #5 clk = ~clk;

    dmem_arbiter #(.ADDRESS_LENGTH(32), .NUM_PORTS(2)) dut (
        .clk(clk), .rst_n(rst_n),
        .req({req1_v, req0_v}), .we({we1_v, we0_v}),
        .size0(size0), .size1(size1), .uns({uns1_v, uns0_v}),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .gnt(gnt), .rvalid(rvalid), .rdata(rdata), .err(err),
        .ram_sb(ram_sb), .ram_sh(ram_sh), .ram_sw(ram_sw),
        .ram_wa(ram_wa), .ram_ra(ram_ra), .ram_wd(ram_wd), .ram_rd(ram_rd)
    );

    // Environment RAM (written only by DUT strobes) and the reference memory (written by the model).
    logic [7:0] env_mem [1024];
    logic [7:0] mdl_mem [1024];
    logic [9:0] rd_base;

    always_comb begin
        rd_base = {ram_ra[9:2], 2'b00};
        ram_rd  = {env_mem[rd_base + 10'd3], env_mem[rd_base + 10'd2],
                   env_mem[rd_base + 10'd1], env_mem[rd_base]};
    end

    always @(posedge clk) begin
        if (ram_sw)
            for (int k = 0; k < 4; k++) env_mem[{ram_wa[9:2], 2'b00} + k] <= ram_wd[8*k +: 8];
        if (ram_sh)
            for (int k = 0; k < 2; k++) env_mem[{ram_wa[9:1], 1'b0} + k] <= ram_wd[8*k +: 8];
        if (ram_sb)
            env_mem[ram_wa[9:0]] <= ram_wd[7:0];
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int vectors = 0;
    int miscompares = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    typedef struct {
        bit        we;
        bit [31:0] addr;
        bit [31:0] wdata;
        bit [31:0] rdata;
        bit        err;
        bit [2:0]  strb;      // bit0 sb, bit1 sh, bit2 sw
        int        exp_gcyc;  // -1 when grant timing is not predicted
    } exp_t;

    exp_t sbq0[$];
    exp_t sbq1[$];
    int   glog_port[$];
    int   glog_cyc[$];

    // Reference: little-endian byte memory, alignment rule, sign/zero extension by arithmetic.
    function automatic exp_t model(bit we, bit [1:0] size, bit uns, bit [31:0] addr, bit [31:0] wdata);
        exp_t e;
        int   nb;
        int   a;
        bit [31:0] v;
        e.we = we; e.addr = addr; e.wdata = wdata; e.rdata = 0; e.strb = 0; e.exp_gcyc = -1;
        e.err = (size == 2'd3) || (size == 2'd1 && addr % 2 != 0) || (size == 2'd2 && addr % 4 != 0);
        if (e.err) return e;
        nb = 1 << size;
        a  = int'(addr[9:0]);
        if (we) begin
            e.strb = 3'b001 << size;
            for (int k = 0; k < nb; k++) mdl_mem[a + k] = wdata[8*k +: 8];
        end else begin
            v = 0;
            for (int k = 0; k < nb; k++) v = v | (32'(mdl_mem[a + k]) << (8 * k));
            if (!uns && nb < 4 && v[8*nb - 1]) v = v | (32'hFFFF_FFFF << (8 * nb));
            e.rdata = v;
        end
        return e;
    endfunction

    task automatic issue(input int p, input bit we, input bit [1:0] size, input bit uns,
                         input bit [31:0] addr, input bit [31:0] wdata, input bit lat_chk);
        exp_t e;
        bit   got;
        e = model(we, size, uns, addr, wdata);
        e.exp_gcyc = lat_chk ? cyc + 1 : -1;
        if (p == 0) begin
            sbq0.push_back(e);
            req0_v = 1'b1; we0_v = we; size0 = size; uns0_v = uns; addr0 = addr; wdata0 = wdata;
        end else begin
            sbq1.push_back(e);
            req1_v = 1'b1; we1_v = we; size1 = size; uns1_v = uns; addr1 = addr; wdata1 = wdata;
        end
        got = 1'b0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            got = gnt[p];
        end
        if (p == 0) req0_v = 1'b0; else req1_v = 1'b0;
        if (!got) begin
            vectors++;
            miscompares++;
            $display("FAIL gnt_timeout: port %0d got no gnt in 40 cycles, required a gnt", p);
        end
    endtask

    task automatic wait_idle();
        int i;
        for (i = 0; i < 60; i++) begin
            if (sbq0.size() == 0 && sbq1.size() == 0) break;
            @(negedge clk);
        end
        if (i == 60) begin
            vectors++;
            miscompares++;
            $display("FAIL rvalid_timeout: %0d/%0d responses outstanding, required 0", sbq0.size(), sbq1.size());
        end
        @(negedge clk);
    endtask

    task automatic one(input int p, input bit we, input bit [1:0] size, input bit uns,
                       input bit [31:0] addr, input bit [31:0] wdata);
        issue(p, we, size, uns, addr, wdata, 1'b1);
        wait_idle();
    endtask

    task automatic rand_drv(input int p, input int n);
        bit [31:0] base;
        bit [1:0]  size;
        int        off;
        base = (p == 0) ? 32'h0001_0000 : 32'h0001_0200;
        for (int i = 0; i < n; i++) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            size = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            off  = int'($urandom_range(0, 508));
            if ($urandom_range(0, 3) != 0) off = off & ~((1 << size) - 1);
            issue(p, 1'($urandom_range(0, 1)), size, 1'($urandom_range(0, 1)),
                  base + 32'(off), $urandom, 1'b0);
        end
    endtask

    // Monitor: strobe sanity every cycle; gnt/rvalid checked against the head of each port's queue.
    int   gcyc [2];
    exp_t me;
    always @(negedge clk) begin
        check("strobe_onehot", 32'($countones({ram_sb, ram_sh, ram_sw}) <= 1), 32'd1);
        check("strobe_without_gnt", 32'((ram_sb | ram_sh | ram_sw) && gnt == 2'b00), 32'd0);
        for (int p = 0; p < 2; p++) begin
            if (gnt[p]) begin
                vectors++;
                if ((p == 0 ? sbq0.size() : sbq1.size()) == 0) begin
                    miscompares++;
                    $display("FAIL unexpected_gnt: gnt[%0d]=1, required 0 (nothing pending)", p);
                end else begin
                    me = (p == 0) ? sbq0[0] : sbq1[0];
                    check("gnt_strobes", 32'({ram_sw, ram_sh, ram_sb}), 32'(me.strb));
                    check("gnt_ram_wa", ram_wa, me.addr);
                    check("gnt_ram_ra", ram_ra, me.addr);
                    if (me.strb != 0) check("gnt_ram_wd", ram_wd, me.wdata);
                    if (me.exp_gcyc >= 0) check("gnt_latency_cycle", cyc, me.exp_gcyc);
                end
                gcyc[p] = cyc;
                glog_port.push_back(p);
                glog_cyc.push_back(cyc);
            end
            if (rvalid[p]) begin
                vectors++;
                if ((p == 0 ? sbq0.size() : sbq1.size()) == 0) begin
                    miscompares++;
                    $display("FAIL unexpected_rvalid: rvalid[%0d]=1, required 0 (nothing pending)", p);
                end else begin
                    me = (p == 0) ? sbq0.pop_front() : sbq1.pop_front();
                    check("rvalid_rdata", rdata, me.rdata);
                    check("rvalid_err", 32'(err), 32'(me.err));
                    check("rvalid_after_gnt", cyc, gcyc[p] + 1);
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation exceeded time limit, required completion");
        $fatal(1, "watchdog");
    end

    int base_idx;

    initial begin
        rst_n = 1'b0;
        req0_v = 0; req1_v = 0; we0_v = 0; we1_v = 0; uns0_v = 0; uns1_v = 0;
        size0 = 0; size1 = 0; addr0 = 0; addr1 = 0; wdata0 = 0; wdata1 = 0;
        for (int i = 0; i < 1024; i++) begin
            env_mem[i] = 8'($urandom);
            mdl_mem[i] = env_mem[i];
        end
        repeat (3) @(negedge clk);
        check("reset_gnt", 32'(gnt), 32'd0);
        check("reset_rvalid", 32'(rvalid), 32'd0);
        check("reset_rdata", rdata, 32'd0);
        check("reset_err", 32'(err), 32'd0);
        check("reset_strobes", 32'({ram_sb, ram_sh, ram_sw}), 32'd0);
        check("reset_ram_wa", ram_wa, 32'd0);
        check("reset_ram_ra", ram_ra, 32'd0);
        check("reset_ram_wd", ram_wd, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Directed accesses, each from an idle arbiter so grant latency is checked.
        one(0, 1'b1, 2'd2, 1'b0, 32'h0001_0000, 32'hDEAD_BEEF);
        one(0, 1'b0, 2'd2, 1'b0, 32'h0001_0000, 32'h0);
        one(0, 1'b1, 2'd2, 1'b0, 32'h0001_0000, 32'h1234_F600);
        one(0, 1'b0, 2'd0, 1'b0, 32'h0001_0001, 32'h0);
        one(0, 1'b0, 2'd0, 1'b1, 32'h0001_0001, 32'h0);
        one(1, 1'b0, 2'd1, 1'b0, 32'h0001_0003, 32'h0);
        one(1, 1'b1, 2'd1, 1'b0, 32'h0001_0002, 32'h0000_ABCD);
        one(1, 1'b0, 2'd1, 1'b1, 32'h0001_0002, 32'h0);
        one(1, 1'b0, 2'd1, 1'b0, 32'h0001_0002, 32'h0);
        one(0, 1'b1, 2'd3, 1'b0, 32'h0001_0004, 32'h1111_1111);
        one(0, 1'b1, 2'd2, 1'b0, 32'h0001_0006, 32'h2222_2222);
        one(0, 1'b1, 2'd0, 1'b0, 32'h0001_0007, 32'h0000_0033);
        one(0, 1'b0, 2'd2, 1'b0, 32'h0001_0004, 32'h0);

        // Both ports requesting continuously straight after reset.
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        base_idx = glog_port.size();
        fork
            begin
                issue(0, 1'b0, 2'd2, 1'b0, 32'h0001_0100, 32'h0, 1'b0);
                issue(0, 1'b0, 2'd2, 1'b0, 32'h0001_0104, 32'h0, 1'b0);
            end
            begin
                issue(1, 1'b0, 2'd2, 1'b0, 32'h0001_0200, 32'h0, 1'b0);
                issue(1, 1'b0, 2'd2, 1'b0, 32'h0001_0204, 32'h0, 1'b0);
            end
        join
        wait_idle();
        check("rr_grant_count", 32'(glog_port.size() - base_idx), 32'd4);
        if (glog_port.size() >= base_idx + 4) begin
            for (int i = 0; i < 4; i++) check("rr_order", 32'(glog_port[base_idx + i]), 32'(i % 2));
            for (int i = 1; i < 4; i++)
                check("rr_spacing", 32'(glog_cyc[base_idx + i] - glog_cyc[base_idx + i - 1]), 32'd2);
        end

        // Reset asserted during the ACCESS cycle of a word store: nothing may reach the RAM.
        req0_v = 1'b1; we0_v = 1'b1; size0 = 2'd2; uns0_v = 1'b0;
        addr0 = 32'h0001_0008; wdata0 = 32'hCAFE_F00D;
        @(posedge clk);
        #1;
        rst_n  = 1'b0;
        req0_v = 1'b0;
        @(negedge clk);
        check("rst_access_sw", 32'(ram_sw), 32'd0);
        check("rst_access_gnt", 32'(gnt), 32'd0);
        repeat (3) begin
            @(negedge clk);
            check("rst_rvalid", 32'(rvalid), 32'd0);
            check("rst_ram_wa", ram_wa, 32'd0);
            check("rst_rdata", rdata, 32'd0);
            check("rst_err", 32'(err), 32'd0);
        end
        rst_n = 1'b1;
        one(0, 1'b0, 2'd2, 1'b0, 32'h0001_0008, 32'h0);

        // Random concurrent traffic, each port in its own address window.
        fork
            rand_drv(0, 200);
            rand_drv(1, 200);
        join
        wait_idle();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
